// File: rtl/taylor_pkg.sv
// rtl/taylor_pkg.sv - shared constants and FSM state type for the Taylor sweep driver
package taylor_pkg;

    localparam int W         = 18;
    localparam int FXP_SHIFT = 16;
    localparam int FXP_ONE   = 1 << FXP_SHIFT;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ISSUE  = 3'd1,
        WAIT   = 3'd2,
        STORE  = 3'd3,
        FINISH = 3'd4
    } state_t;

endpackage

// File: rtl/taylor_result_fifo.sv
// rtl/taylor_result_fifo.sv - first-word-fall-through result FIFO, power-of-two depth
module taylor_result_fifo #(
    parameter int W     = 18,
    parameter int DEPTH = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] rd_data,
    output logic         empty,
    output logic         full
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic [W-1:0] mem [DEPTH];
    logic         do_push;
    logic         do_pop;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/taylor_sweep_driver.sv
// rtl/taylor_sweep_driver.sv - sweeps angles through an external cosine unit into a result FIFO
// Optional WAIT watchdog enabled by TAYLOR_SWEEP_TIMEOUT_EN.
module taylor_sweep_driver #(
    parameter int W     = taylor_pkg::W,
    parameter int DEPTH = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         go,
    input  logic [W-1:0] angle_base,
    input  logic [W-1:0] angle_step,
    input  logic [4:0]   num_samples,
    output logic         start_out,
    output logic [W-1:0] angle_out,
    input  logic         ready_in,
    input  logic [W-1:0] result_in,
    input  logic         rd_en,
    output logic [W-1:0] rd_data,
    output logic         empty,
    output logic         busy,
    output logic         done,
    output logic         timeout_err
);

    import taylor_pkg::*;

    state_t       state;
    state_t       state_nxt;
    logic [4:0]   remaining;
    logic         ready_q;
    logic [W-1:0] result_q;
    logic         ready_rise;
    logic         fifo_full;
    logic         store_ok;
    logic         timeout_hit;
    logic         advance;
    logic         last_sample;

    // A ready level carried over from the previous operation never counts.
    assign ready_rise  = ready_in && !ready_q;
    assign store_ok    = (state == STORE) && !fifo_full;
    assign advance     = store_ok || timeout_hit;
    assign last_sample = (remaining == 5'd1);

`ifdef TAYLOR_SWEEP_TIMEOUT_EN
    logic [5:0] wdog;
    logic       timeout_q;

    assign timeout_hit = (state == WAIT) && !ready_rise && (wdog == 6'd63);
    assign timeout_err = timeout_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wdog      <= '0;
            timeout_q <= 1'b0;
        end else begin
            wdog <= (state == WAIT) ? wdog + 6'd1 : 6'd0;
            if (timeout_hit) begin
                timeout_q <= 1'b1;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            angle_out <= '0;
            remaining <= '0;
            ready_q   <= 1'b0;
            result_q  <= '0;
        end else begin
            ready_q <= ready_in;
            if (state == IDLE && go) begin
                angle_out <= angle_base;
                remaining <= num_samples;
            end
            if (state == WAIT && ready_rise) begin
                result_q <= result_in;
            end
            // Angle wraps modulo 2^W by design.
            if (advance) begin
                angle_out <= angle_out + angle_step;
                remaining <= remaining - 5'd1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (go) begin
                    state_nxt = (num_samples != 5'd0) ? ISSUE : FINISH;
                end
            end
            ISSUE: state_nxt = WAIT;
            WAIT: begin
                if (ready_rise) begin
                    state_nxt = STORE;
                end else if (timeout_hit) begin
                    state_nxt = last_sample ? FINISH : ISSUE;
                end
            end
            STORE: begin
                if (!fifo_full) begin
                    state_nxt = last_sample ? FINISH : ISSUE;
                end
            end
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        start_out = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            IDLE:         busy      = 1'b0;
            ISSUE, WAIT:  start_out = 1'b1;
            FINISH:       done      = 1'b1;
            default:      start_out = 1'b0;
        endcase
    end

    taylor_result_fifo #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (store_ok),
        .push_data (result_q),
        .pop       (rd_en),
        .rd_data   (rd_data),
        .empty     (empty),
        .full      (fifo_full)
    );

endmodule

// File: tb/tb_taylor_sweep_driver.sv
// tb/tb_taylor_sweep_driver.sv - directed scoreboard bench for taylor_sweep_driver
module tb_taylor_sweep_driver;

    localparam int W     = 18;
    localparam int DEPTH = 8;
    localparam logic [W-1:0] ONE = 18'h10000;

    logic         clock;
    logic         reset;
    logic         go;
    logic [W-1:0] angle_base;
    logic [W-1:0] angle_step;
    logic [4:0]   num_samples;
    logic         start_out;
    logic [W-1:0] angle_out;
    logic         ready_in;
    logic [W-1:0] result_in;
    logic         rd_en;
    logic [W-1:0] rd_data;
    logic         empty;
    logic         busy;
    logic         done;
    logic         timeout_err;

    int total = 0;
    int bad   = 0;
    int done_cnt = 0;
    int rise_cnt = 0;
    logic start_q = 1'b0;
    logic stub_en = 1'b1;
    logic [W-1:0] exp_q [$];
    logic [W-1:0] ang_q [$];

    taylor_sweep_driver #(.W(W), .DEPTH(DEPTH)) dut (
        .clock       (clock),
        .reset       (reset),
        .go          (go),
        .angle_base  (angle_base),
        .angle_step  (angle_step),
        .num_samples (num_samples),
        .start_out   (start_out),
        .angle_out   (angle_out),
        .ready_in    (ready_in),
        .result_in   (result_in),
        .rd_en       (rd_en),
        .rd_data     (rd_data),
        .empty       (empty),
        .busy        (busy),
        .done        (done),
        .timeout_err (timeout_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Stand-in cosine: result = ONE - angle (mod 2^W), so angle 0 gives 1.0.
    function automatic logic [W-1:0] fake_cos(input logic [W-1:0] a);
        return ONE - a;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Cosine unit stub: holds ready high into the next ISSUE and first WAIT cycle.
    initial begin : stub
        logic [W-1:0] a;
        ready_in  = 1'b0;
        result_in = '0;
        forever begin
            @(negedge clock);
            if (stub_en && start_out && reset) begin
                a = angle_out;
                @(negedge clock);
                @(negedge clock);
                ready_in = 1'b0;
                repeat (3) @(negedge clock);
                result_in = fake_cos(a);
                ready_in  = 1'b1;
                for (int k = 0; k < 50 && start_out; k++) @(negedge clock);
            end
        end
    end

    initial begin : monitor
        forever begin
            @(negedge clock);
            if (done) done_cnt++;
            if (start_out && !start_q) begin
                rise_cnt++;
                ang_q.push_back(angle_out);
            end
            start_q = start_out;
        end
    end

    task automatic start_sweep(input logic [W-1:0] base, input logic [W-1:0] step, input int n);
        logic [W-1:0] a;
        @(posedge clock);
        #1;
        angle_base  = base;
        angle_step  = step;
        num_samples = n[4:0];
        go          = 1'b1;
        a = base;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(fake_cos(a));
            a = a + step;
        end
        @(posedge clock);
        #1;
        go = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget, output int cycles);
        cycles = 0;
        while (!done && cycles < budget) begin
            @(negedge clock);
            cycles++;
        end
        check(tag, {31'd0, done}, 32'd1);
    endtask

    task automatic drain(input string tag, input int budget, input int expect_n);
        int got = 0;
        int n = 0;
        while (got < expect_n && n < budget) begin
            @(negedge clock);
            n++;
            if (!empty) begin
                if (exp_q.size() > 0) check({tag, "_data"}, {14'd0, rd_data}, {14'd0, exp_q.pop_front()});
                else check({tag, "_extra"}, {14'd0, rd_data}, 32'hFFFF_FFFF);
                got++;
                rd_en = 1'b1;
            end else begin
                rd_en = 1'b0;
            end
        end
        @(negedge clock);
        rd_en = 1'b0;
        check({tag, "_count"}, got, expect_n);
        check({tag, "_empty"}, {31'd0, empty}, 32'd1);
    endtask

    initial begin : main
        int cyc;
        int base_done;
        int base_rise;
        reset       = 1'b0;
        go          = 1'b0;
        angle_base  = '0;
        angle_step  = '0;
        num_samples = '0;
        rd_en       = 1'b0;

        repeat (3) @(negedge clock);
        check("rst_start", {31'd0, start_out}, 32'd0);
        check("rst_angle", {14'd0, angle_out}, 32'd0);
        check("rst_busy",  {31'd0, busy}, 32'd0);
        check("rst_done",  {31'd0, done}, 32'd0);
        check("rst_empty", {31'd0, empty}, 32'd1);
        check("rst_rdata", {14'd0, rd_data}, 32'd0);
        check("rst_tmo",   {31'd0, timeout_err}, 32'd0);
        reset = 1'b1;
        repeat (2) @(negedge clock);

        // Three samples at angle 0 -> three entries of 1.0, single done.
        base_done = done_cnt;
        start_sweep('0, '0, 3);
        check("s3_busy", {31'd0, busy}, 32'd1);
        wait_done("s3_done", 200, cyc);
        repeat (3) @(negedge clock);
        check("s3_done_once", done_cnt - base_done, 32'd1);
        check("s3_head", {14'd0, rd_data}, {14'd0, ONE});
        drain("s3", 50, 3);

        // Zero samples: done within 2 cycles, no start, FIFO stays empty.
        base_rise = rise_cnt;
        start_sweep('0, 18'h100, 0);
        wait_done("z_done", 5, cyc);
        check("z_latency_le2", {31'd0, cyc <= 2}, 32'd1);
        repeat (3) @(negedge clock);
        check("z_no_start", rise_cnt - base_rise, 32'd0);
        check("z_empty", {31'd0, empty}, 32'd1);

        // Twelve samples with no reads: stall after DEPTH pushes, then drain in order.
        base_done = done_cnt;
        start_sweep(18'h01000, 18'h00800, 12);
        repeat (150) @(negedge clock);
        check("st_busy",  {31'd0, busy}, 32'd1);
        check("st_start", {31'd0, start_out}, 32'd0);
        check("st_done",  done_cnt - base_done, 32'd0);
        base_rise = rise_cnt;
        repeat (20) @(negedge clock);
        check("st_hold", rise_cnt - base_rise, 32'd0);
        drain("st", 400, 12);
        check("st_done_once", done_cnt - base_done, 32'd1);
        check("st_idle", {31'd0, busy}, 32'd0);

        // Angle wrap-around.
        ang_q.delete();
        start_sweep(18'h3FFF0, 18'h00020, 2);
        wait_done("wr_done", 100, cyc);
        check("wr_n_angles", ang_q.size(), 32'd2);
        if (ang_q.size() == 2) begin
            check("wr_angle0", {14'd0, ang_q[0]}, 32'h3FFF0);
            check("wr_angle1", {14'd0, ang_q[1]}, 32'h00010);
        end
        drain("wr", 50, 2);

        // Reset during WAIT of the second sample, with one result buffered.
        base_rise = rise_cnt;
        start_sweep('0, 18'h00100, 3);
        cyc = 0;
        while (rise_cnt - base_rise < 2 && cyc < 100) begin
            @(negedge clock);
            cyc++;
        end
        check("rw_reached", rise_cnt - base_rise, 32'd2);
        @(negedge clock);
        check("rw_buffered", {31'd0, empty}, 32'd0);
        check("rw_in_wait", {31'd0, start_out}, 32'd1);
        base_done = done_cnt;
        reset = 1'b0;
        #1;
        check("rw_start", {31'd0, start_out}, 32'd0);
        check("rw_angle", {14'd0, angle_out}, 32'd0);
        check("rw_busy",  {31'd0, busy}, 32'd0);
        check("rw_empty", {31'd0, empty}, 32'd1);
        check("rw_rdata", {14'd0, rd_data}, 32'd0);
        @(posedge clock);
        #1;
        check("rw_done", {31'd0, done}, 32'd0);
        check("rw_empty2", {31'd0, empty}, 32'd1);
        exp_q.delete();
        @(negedge clock);
        reset = 1'b1;
        repeat (20) @(negedge clock);
        check("rw_no_done", done_cnt - base_done, 32'd0);
        start_sweep(18'h00100, 18'h00040, 4);
        wait_done("rw2_done", 200, cyc);
        drain("rw2", 50, 4);

`ifdef TAYLOR_SWEEP_TIMEOUT_EN
        // Watchdog: cosine unit never answers.
        stub_en  = 1'b0;
        ready_in = 1'b0;
        repeat (2) @(negedge clock);
        start_sweep('0, '0, 1);
        cyc = 0;
        while (!timeout_err && cyc < 100) begin
            @(negedge clock);
            cyc++;
        end
        check("to_flag", {31'd0, timeout_err}, 32'd1);
        check("to_window", {31'd0, (cyc >= 60) && (cyc <= 68)}, 32'd1);
        wait_done("to_done", 10, cyc);
        repeat (2) @(negedge clock);
        check("to_no_push", {31'd0, empty}, 32'd1);
        check("to_sticky", {31'd0, timeout_err}, 32'd1);
        exp_q.delete();
`else
        check("to_tied", {31'd0, timeout_err}, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/taylor_sweep_driver.md
TAYLOR_SWEEP_DRIVER -- requirements
Module: taylor_sweep_driver

Interface
REQ-001 Parameter W, 18, fixed-point sample width; Q2.16 format, FXP_SHIFT = 16.
REQ-002 Parameter DEPTH, 8, result FIFO depth in entries; power of two.
REQ-003 clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 go  input  1  sweep request; sampled only in IDLE.
REQ-006 angle_base  input  W  first angle of the sweep, Q2.16.
REQ-007 angle_step  input  W  angle increment per sample, Q2.16.
REQ-008 num_samples  input  5  samples per sweep; 0 is legal.
REQ-009 start_out  output  1  start request to the cosine unit.
REQ-010 angle_out  output  W  angle presented to the cosine unit.
REQ-011 ready_in  input  1  ready flag from the cosine unit.
REQ-012 result_in  input  W  cosine result from the cosine unit, Q2.16.
REQ-013 rd_en  input  1  FIFO pop request.
REQ-014 rd_data  output  W  FIFO head; valid when empty is 0.
REQ-015 empty  output  1  FIFO holds no entries.
REQ-016 busy  output  1  sweep in progress, i.e. state is not IDLE.
REQ-017 done  output  1  one-cycle pulse when a sweep completes.
REQ-018 timeout_err  output  1  sticky watchdog error flag (see Configuration).

Function
REQ-019 The FSM SHALL have states IDLE, ISSUE, WAIT, STORE and FINISH.
REQ-020 In IDLE with go=1, the block SHALL latch angle_base into angle_out and num_samples into a remaining counter.
REQ-021 On that go=1 in IDLE, the block SHALL enter ISSUE if num_samples != 0, else FINISH.
REQ-022 start_out SHALL be 1 exactly in ISSUE and WAIT, and 0 in all other states.
REQ-023 angle_out SHALL stay constant from ISSUE entry until STORE exits.
REQ-024 ISSUE SHALL last one cycle and then enter WAIT.
REQ-025 A registered copy of ready_in SHALL be kept, and WAIT SHALL detect the rising edge (ready_in=1 with the registered copy 0).
REQ-026 A level-high ready_in left over from the previous operation SHALL NOT be taken as completion.
REQ-027 On the rising edge of ready_in, result_in SHALL be captured and the FSM SHALL enter STORE.
REQ-028 In STORE, if the FIFO is not full, the block SHALL push the captured result, add angle_step to angle_out (modulo 2^W, wrap-around is silent) and decrement the remaining counter.
REQ-029 After that push, STORE SHALL go to ISSUE if the remaining count is nonzero, else to FINISH.
REQ-030 In STORE with the FIFO full, the block SHALL hold (no push, start_out=0) until space frees.
REQ-031 FINISH SHALL pulse done=1 for one cycle and return to IDLE.
REQ-032 go while busy=1 SHALL be ignored.
REQ-033 The FIFO SHALL update from rd_en=1 with empty=0 in the same cycle as a STORE push; both SHALL take effect and the occupancy is unchanged.
REQ-034 rd_en with empty=1 SHALL be ignored.
REQ-035 rd_data SHALL be first-word-fall-through.

Reset
REQ-036 While reset=0: state=IDLE, start_out=0, angle_out=0, busy=0, done=0, timeout_err=0, FIFO emptied (empty=1), rd_data=0, registered ready copy=0.
REQ-037 Reset asserted mid-sweep SHALL abandon the sweep immediately, discard buffered results and produce no done pulse.

Configuration
REQ-038 With TAYLOR_SWEEP_TIMEOUT_EN defined, a 6-bit watchdog SHALL count cycles spent in WAIT.
REQ-039 At a watchdog count of 63, the block SHALL set timeout_err=1 (sticky until reset), skip the sample with no push, and proceed as if STORE completed.
REQ-040 Without TAYLOR_SWEEP_TIMEOUT_EN, WAIT SHALL wait indefinitely and timeout_err SHALL be tied to 0.

Structure
REQ-041 Package taylor_pkg SHALL hold W, FXP_SHIFT, FXP_ONE (65536) and the FSM state enum typedef.
REQ-042 The FIFO SHALL be sub-module taylor_result_fifo (parameters W and DEPTH).

Verification
REQ-043 Sweep with angle_base=0, angle_step=0, num_samples=3, against the cosine unit -> three FIFO entries of 65536, then done pulses once.
REQ-044 num_samples=0 with go=1 -> done pulse within 2 cycles, start_out never asserted, empty stays 1.
REQ-045 num_samples=12, DEPTH=8, rd_en=0 -> stall in STORE after 8 pushes with start_out=0; popping then lets the sweep finish with all 12 results delivered in order.
REQ-046 angle_base=0x3FFF0, angle_step=0x00020 -> the second angle_out is 0x00010 (wrap).
REQ-047 reset=0 asserted during WAIT -> next cycle all outputs at reset values; a new sweep then runs cleanly.
REQ-048 With TAYLOR_SWEEP_TIMEOUT_EN defined and ready_in held 0 -> timeout_err=1 after 63 WAIT cycles, and the sweep still ends with a done pulse.
